slurm16_fetch: RTL and testbench
================================

Name: slurm16_fetch

Overview:
- Instruction fetch unit directly upstream of pipeline16 in the slurm16 core.
- Owns the program counter and issues word reads to the memory controller.
- Buffers returned instruction words, each with its PC, in a small prefetch FIFO that pipeline16 drains through a valid/ready handshake.
- Accepts branch redirects from the pipeline: flushes buffered and in-flight words, then restarts fetch at the target.

Parameters:
- BITS, 16, instruction/data word width
- ADDRESS_BITS, 16, word address width
- DEPTH, 4, prefetch FIFO entries (power of two, >=2)
- RESET_PC, 0, fetch address after reset

Ports:
- CLK  in  1  core clock
- RST  in  1  asynchronous active-high reset
- fetch_en  in  1  1 = fetching allowed; 0 = no new mem_req (in-flight data still accepted)
- mem_req  out  1  read request to memory controller
- mem_addr  out  ADDRESS_BITS  word address of request
- mem_gnt  in  1  request accepted this cycle
- mem_rdata  in  BITS  read data
- mem_rvalid  in  1  mem_rdata valid; always exactly 1 cycle after a granted request
- instr  out  BITS  head-of-FIFO instruction
- instr_pc  out  ADDRESS_BITS  address of instr
- instr_valid  out  1  FIFO non-empty
- instr_ready  in  1  pipeline16 consumes head when instr_valid && instr_ready
- branch_req  in  1  redirect request (single-cycle pulse)
- branch_target  in  ADDRESS_BITS  new fetch address
- fetch_pc  out  ADDRESS_BITS  next address to be requested (debug)

Behaviour:
- Reset values (asynchronous): mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, FIFO empty, inflight=0, discard=0.
- mem_addr always equals fetch_pc.
- mem_req = fetch_en && !branch_req && (count + inflight < DEPTH). The request is combinational from registered state.
- On mem_gnt && mem_req:
  - fetch_pc <= fetch_pc + 1, wrapping 0xFFFF -> 0x0000.
  - inflight <= 1, and the issued address is latched as req_pc.
  - Otherwise inflight <= 0.
  - Back-to-back grants are allowed, one per cycle.
- On mem_rvalid && !discard: push {mem_rdata, req_pc}. By the credit rule a push never occurs when the FIFO is full. mem_rvalid with inflight=0 is a protocol error and is ignored.
- FIFO is show-ahead: instr/instr_pc/instr_valid reflect the head register.
  - Pop on instr_valid && instr_ready.
  - Simultaneous push and pop allowed at any occupancy, including count=1: the pushed word becomes the new head next cycle.
- Latency: grant in cycle N gives data in N+1 and instr_valid in N+2.
- Branch (branch_req=1 in cycle N):
  - Branch has priority over push and pop.
  - No mem_req in cycle N.
  - At the edge ending cycle N: FIFO cleared (count=0, instr_valid=0), fetch_pc <= branch_target.
  - discard <= inflight || (mem_gnt && mem_req), which is always inflight because mem_req=0.
  - Any mem_rvalid in cycle N+1 is dropped when discard=1; discard clears after one cycle.
  - A pop coinciding with branch_req is ignored.
  - Cycle N+1: mem_req with mem_addr=branch_target (if fetch_en).
- Branch to the current fetch_pc is still a full flush.
- Consecutive branch_req cycles: the last target wins; no requests are issued while branch_req is held.
- fetch_en=0:
  - No new requests.
  - The pending return is still pushed.
  - FIFO still drains.
- Reset mid-operation: all state returns to reset values immediately. mem_rvalid in the following cycle is ignored because inflight=0.

Test Plan:
- Reset, fetch_en=1, mem_gnt=1, instr_ready=1, memory returns word = address^16'hA5A5 → mem_addr 0,1,2,... each cycle; instr_valid from cycle 2; instr_pc 0,1,2 with instr 16'hA5A5,16'hA5A4,16'hA5A7.
- instr_ready=0 with continuous grants, DEPTH=4 → exactly 4 grants, then mem_req=0 holding mem_addr=4. Raise instr_ready for one cycle → exactly one further request at address 4.
- branch_req with target 16'h1234, asserted the cycle after a grant to address 7 → the address-7 data is dropped. instr_valid=0 the next cycle; mem_addr=16'h1234 the cycle after the branch; first instr_pc after the branch is 16'h1234.
- RESET_PC=16'hFFFE, free-running fetch → instr_pc sequence FFFE, FFFF, 0000, 0001.
- mem_gnt toggling 1,0,0,1 with instr_ready random → instr_pc strictly consecutive, no duplicates or gaps, count never exceeds DEPTH.
- RST pulsed while FIFO holds 3 entries and one request is in flight → all outputs return to reset values immediately. The stale mem_rvalid is not pushed; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/slurm16_fetch.sv
// Slurm16 instruction fetch: owns the program counter, issues single-word reads
// and buffers returned words with their PC in a show-ahead prefetch FIFO.
module slurm16_fetch #(
  parameter int BITS = 16,
  parameter int ADDRESS_BITS = 16,
  parameter int DEPTH = 4,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    fetch_en,
  output logic                    mem_req,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  input  logic                    mem_gnt,
  input  logic [BITS-1:0]         mem_rdata,
  input  logic                    mem_rvalid,
  output logic [BITS-1:0]         instr,
  output logic [ADDRESS_BITS-1:0] instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  input  logic                    branch_req,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  output logic [ADDRESS_BITS-1:0] fetch_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [BITS-1:0]         data_q [DEPTH];
  logic [ADDRESS_BITS-1:0] pc_q   [DEPTH];
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [CW-1:0]           count;
  logic                    inflight;
  logic                    discard;
  logic [ADDRESS_BITS-1:0] req_pc;
  logic [CW:0]             credit_used;
  logic                    grant;
  logic                    push;
  logic                    pop;

  // A slot is reserved for every outstanding read, so a return can never overflow.
  always_comb begin
    credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    mem_req     = fetch_en && !branch_req && (credit_used < DEPTH_C);
    grant       = mem_req && mem_gnt;
    push        = mem_rvalid && inflight && !discard && !branch_req;
    pop         = instr_valid && instr_ready && !branch_req;
  end

  assign mem_addr    = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr       = data_q[rd_ptr];
  assign instr_pc    = pc_q[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      discard  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (branch_req) begin
      fetch_pc <= branch_target;
      discard  <= inflight;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      discard  <= 1'b0;
      inflight <= grant;
      if (grant) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + ADDRESS_BITS'(1);
      end
      if (push) begin
        data_q[wr_ptr] <= mem_rdata;
        pc_q[wr_ptr]   <= req_pc;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slurm16_fetch.sv
// Bench for slurm16_fetch: queue-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_slurm16_fetch;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        fetch_en = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic        instr_ready = 1'b0, branch_req = 1'b0;
  logic [15:0] mem_rdata = '0, branch_target = '0;
  logic        mem_req, instr_valid;
  logic [15:0] mem_addr, instr, instr_pc, fetch_pc;

  logic        fe2 = 1'b0, mem_rvalid2 = 1'b0;
  logic        gnt2 = 1'b1, rdy2 = 1'b1, br2 = 1'b0;
  logic [15:0] mem_rdata2 = '0, tgt2 = '0;
  logic        mem_req2, instr_valid2;
  logic [15:0] mem_addr2, instr2, instr_pc2, fetch_pc2;

  slurm16_fetch #(.BITS(16), .ADDRESS_BITS(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .CLK(CLK), .RST(RST), .fetch_en(fetch_en), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_req(branch_req), .branch_target(branch_target), .fetch_pc(fetch_pc));

  slurm16_fetch #(.BITS(16), .ADDRESS_BITS(16), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut2 (
    .CLK(CLK), .RST(RST), .fetch_en(fe2), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_gnt(gnt2), .mem_rdata(mem_rdata2), .mem_rvalid(mem_rvalid2), .instr(instr2),
    .instr_pc(instr_pc2), .instr_valid(instr_valid2), .instr_ready(rdy2),
    .branch_req(br2), .branch_target(tgt2), .fetch_pc(fetch_pc2));

  initial forever #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO contents as {word, pc}, next fetch address,
  // and whether one read is outstanding.
  logic [31:0] q[$];
  logic [15:0] m_pc, m_ipc;
  bit          m_inflight, m_discard;

  logic        nxt_rvalid = 1'b0, nxt2 = 1'b0;
  logic [15:0] nxt_rdata = '0, nxt_rdata2 = '0;

  logic        s_req, s_valid, s2_valid;
  logic [15:0] s_addr, s_pc, s_instr, s2_pc, s2_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc       = 16'h0000;
    m_ipc      = 16'h0000;
    m_inflight = 1'b0;
    m_discard  = 1'b0;
  endtask

  task automatic step(input bit fe, input bit g, input bit rdy, input bit br,
                      input logic [15:0] tgt);
    bit exp_req;
    bit push_ok;
    @(negedge CLK);
    fetch_en = fe; mem_gnt = g; instr_ready = rdy; branch_req = br; branch_target = tgt;
    mem_rvalid = nxt_rvalid; mem_rdata = nxt_rdata;
    fe2 = fe; mem_rvalid2 = nxt2; mem_rdata2 = nxt_rdata2;
    #1;
    s_req = mem_req; s_addr = mem_addr; s_valid = instr_valid; s_pc = instr_pc; s_instr = instr;
    s2_valid = instr_valid2; s2_pc = instr_pc2; s2_instr = instr2;
    exp_req = fe && !br && ((q.size() + int'(m_inflight)) < DEPTH);
    chk("mem_req", 32'(mem_req), 32'(exp_req));
    chk("mem_addr", 32'(mem_addr), 32'(m_pc));
    chk("fetch_pc", 32'(fetch_pc), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("instr", 32'(instr), 32'(q[0][31:16]));
      chk("instr_pc", 32'(instr_pc), 32'(q[0][15:0]));
    end
    // memory answers exactly one cycle after any granted request
    nxt_rvalid = mem_req && mem_gnt;  nxt_rdata  = mem_addr ^ 16'hA5A5;
    nxt2       = mem_req2 && gnt2;    nxt_rdata2 = mem_addr2 ^ 16'hA5A5;
    if (br) begin
      q.delete();
      m_discard  = m_inflight;
      m_inflight = 1'b0;
      m_pc       = tgt;
    end else begin
      push_ok = mem_rvalid && m_inflight && !m_discard;
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (push_ok) q.push_back({mem_rdata, m_ipc});
      m_discard = 1'b0;
      if (exp_req && g) begin
        m_ipc      = m_pc;
        m_pc       = m_pc + 16'd1;
        m_inflight = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
    end
  endtask

  // Asynchronous reset pulse in mid-cycle; any pending return is presented while
  // the design is coming out of reset and must be ignored.
  task automatic do_reset();
    @(negedge CLK);
    fetch_en = 1'b0; mem_gnt = 1'b0; instr_ready = 1'b0; branch_req = 1'b0;
    branch_target = '0; fe2 = 1'b0;
    mem_rvalid = nxt_rvalid; mem_rdata = nxt_rdata;
    mem_rvalid2 = nxt2; mem_rdata2 = nxt_rdata2;
    nxt_rvalid = 1'b0; nxt2 = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("reset_mem_req", 32'(mem_req), 32'(0));
    chk("reset_mem_addr", 32'(mem_addr), 32'(16'h0000));
    chk("reset_fetch_pc", 32'(fetch_pc), 32'(16'h0000));
    chk("reset_instr_valid", 32'(instr_valid), 32'(0));
    chk("reset_instr", 32'(instr), 32'(0));
    chk("reset_instr_pc", 32'(instr_pc), 32'(0));
    chk("reset2_fetch_pc", 32'(fetch_pc2), 32'(16'hFFFE));
    #1 RST = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          grants;
    logic [15:0] gaddr, last, first;
    bit          have_last, found, rdy_r, fe_r, g_r, br_r;
    logic [15:0] tgt_r;

    model_reset();

    // Free-running fetch from reset, both RESET_PC values
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      case (k)
        0: begin chk("a_addr0", 32'(s_addr), 32'(0)); chk("a_req0", 32'(s_req), 32'(1));
                 chk("a_valid0", 32'(s_valid), 32'(0)); end
        1: begin chk("a_addr1", 32'(s_addr), 32'(1)); chk("a_valid1", 32'(s_valid), 32'(0)); end
        2: begin chk("a_valid2", 32'(s_valid), 32'(1)); chk("a_pc2", 32'(s_pc), 32'(0));
                 chk("a_instr2", 32'(s_instr), 32'(16'hA5A5)); chk("a_addr2", 32'(s_addr), 32'(2));
                 chk("w_pc0", 32'(s2_pc), 32'(16'hFFFE)); chk("w_valid0", 32'(s2_valid), 32'(1));
                 chk("w_instr0", 32'(s2_instr), 32'(16'h5A5B)); end
        3: begin chk("a_pc3", 32'(s_pc), 32'(1)); chk("a_instr3", 32'(s_instr), 32'(16'hA5A4));
                 chk("w_pc1", 32'(s2_pc), 32'(16'hFFFF)); end
        4: begin chk("a_pc4", 32'(s_pc), 32'(2)); chk("a_instr4", 32'(s_instr), 32'(16'hA5A7));
                 chk("w_pc2", 32'(s2_pc), 32'(16'h0000)); end
        default: chk("w_pc3", 32'(s2_pc), 32'(16'h0001));
      endcase
    end

    // Credit limit with a stalled consumer
    do_reset();
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      if (s_req) grants++;
    end
    chk("credit_grants", 32'(grants), 32'(4));
    chk("credit_stall_req", 32'(s_req), 32'(0));
    chk("credit_stall_addr", 32'(s_addr), 32'(4));
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    grants = 0; gaddr = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      if (s_req) begin grants++; gaddr = s_addr; end
    end
    chk("credit_one_more", 32'(grants), 32'(1));
    chk("credit_one_more_addr", 32'(gaddr), 32'(4));

    // Branch right after the grant to address 7
    do_reset();
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("br_pre_addr", 32'(s_addr), 32'(7));
    chk("br_pre_req", 32'(s_req), 32'(1));
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    chk("br_no_req", 32'(s_req), 32'(0));
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("br_flush_valid", 32'(s_valid), 32'(0));
    chk("br_target_addr", 32'(s_addr), 32'(16'h1234));
    chk("br_target_req", 32'(s_req), 32'(1));
    found = 1'b0; first = '0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      if (s_valid && !found) begin found = 1'b1; first = s_pc; end
    end
    chk("br_first_found", 32'(found), 32'(1));
    chk("br_first_pc", 32'(first), 32'(16'h1234));
    // held branch: last target wins; branch to the current fetch_pc still flushes
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h1111);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h2222);
    chk("br_held_req", 32'(s_req), 32'(0));
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("br_held_addr", 32'(s_addr), 32'(16'h2222));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, m_pc);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("br_self_flush", 32'(s_valid), 32'(0));

    // Grant pattern 1,0,0,1 with random consumer: PCs strictly consecutive
    do_reset();
    have_last = 1'b0; last = '0;
    for (int i = 0; i < 200; i++) begin
      rdy_r = 1'($urandom_range(0, 1));
      step(1'b1, (i % 4 == 0) || (i % 4 == 3), rdy_r, 1'b0, 16'h0);
      if (s_valid && rdy_r) begin
        if (have_last) chk("consecutive_pc", 32'(s_pc), 32'(last + 16'd1));
        last = s_pc; have_last = 1'b1;
      end
    end

    // Fully random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      fe_r  = ($urandom_range(0, 7) != 0);
      g_r   = 1'($urandom_range(0, 1));
      rdy_r = ($urandom_range(0, 3) != 0);
      br_r  = ($urandom_range(0, 15) == 0);
      tgt_r = ($urandom_range(0, 3) == 0) ? m_pc : 16'($urandom);
      step(fe_r, g_r, rdy_r, br_r, tgt_r);
    end

    // Reset with three buffered words and one read in flight
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("rst_pre_valid", 32'(s_valid), 32'(1));
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("rst_stale_dropped", 32'(s_valid), 32'(0));
    chk("rst_restart_addr", 32'(s_addr), 32'(0));
    chk("rst_restart_req", 32'(s_req), 32'(1));
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("rst_still_empty", 32'(s_valid), 32'(0));
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    chk("rst_first_valid", 32'(s_valid), 32'(1));
    chk("rst_first_pc", 32'(s_pc), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
